// File: rtl/cei_mochila_pkg.sv
// Configuration constants and the arbiter index type for the mochila bank arbiter.
package cei_mochila_pkg;

    localparam int NMASTERS_DFLT = 3;

    // Index type for the default configuration; the arbiter re-derives it from its parameter.
    typedef logic [$clog2(NMASTERS_DFLT)-1:0] arb_idx_t;

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response bundles shared by requesters, the arbiter and the RAM bank.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/obi_arb_id_fifo.sv
// Response-routing FIFO holding the requester index of each granted, still-unanswered access.
module obi_arb_id_fifo #(
    parameter int DEPTH = 2,
    parameter int DW    = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [DW-1:0]          data_i,
    output logic [DW-1:0]          data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign full_o  = (r_count == (PW+1)'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign data_o  = r_mem[r_rptr];

    // A push while full is legal only when the head leaves in the same cycle.
    assign w_push = push_i & (~full_o | pop_i);
    assign w_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/obi_bank_arbiter.sv
// Round-robin arbiter letting NMASTERS OBI requesters share one single-cycle RAM bank.
// Define MOCHILA_ARB_FIXED_PRIO_EN to give master 0 absolute priority over the others.
module obi_bank_arbiter
    import obi_pkg::*;
    import cei_mochila_pkg::*;
#(
    parameter int NMASTERS        = NMASTERS_DFLT,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  obi_req_t  master_req_i  [NMASTERS],
    output obi_resp_t master_resp_o [NMASTERS],
    output obi_req_t  bank_req_o,
    input  obi_resp_t bank_resp_i,
    output logic      busy_o
);

    localparam int IW = $clog2(NMASTERS);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    typedef logic [IW-1:0] idx_t;

    function automatic idx_t wrap_add(idx_t a, int b);
        return idx_t'((int'(a) + b) % NMASTERS);
    endfunction

    logic [NMASTERS-1:0] w_req_vec;
    idx_t                r_rr_ptr;
    idx_t                r_lock_idx;
    logic                r_lock_vld;
    idx_t                w_rr_win;
    logic                w_rr_found;
    logic                w_lock_hold;
    idx_t                w_win;
    logic                w_any;
    logic                w_issue;
    logic                w_hs;
    logic                w_pop;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    idx_t                w_head;
    logic [CW-1:0]       w_count;

    always_comb begin
        w_req_vec = '0;
        for (int m = 0; m < NMASTERS; m++) begin
            w_req_vec[m] = master_req_i[m].req;
        end
    end

    always_comb begin
        idx_t cand;
        cand       = '0;
        w_rr_win   = '0;
        w_rr_found = 1'b0;
`ifdef MOCHILA_ARB_FIXED_PRIO_EN
        if (w_req_vec[0]) w_rr_found = 1'b1;
`endif
        for (int i = 0; i < NMASTERS; i++) begin
            cand = wrap_add(r_rr_ptr, i);
`ifdef MOCHILA_ARB_FIXED_PRIO_EN
            if (!w_rr_found && (cand != '0) && w_req_vec[cand]) begin
`else
            if (!w_rr_found && w_req_vec[cand]) begin
`endif
                w_rr_found = 1'b1;
                w_rr_win   = cand;
            end
        end
    end

    // A requester that was offered to the bank but not granted keeps the bank.
    assign w_lock_hold = r_lock_vld & w_req_vec[r_lock_idx];
    assign w_win       = w_lock_hold ? r_lock_idx : w_rr_win;
    assign w_any       = w_lock_hold | w_rr_found;

    assign w_pop   = ~rst_i & bank_resp_i.rvalid & ~w_fifo_empty;
    assign w_issue = ~rst_i & w_any & (~w_fifo_full | w_pop);
    assign w_hs    = w_issue & bank_resp_i.gnt;

    assign bank_req_o = w_issue ? master_req_i[w_win] : '0;
    assign busy_o     = ~rst_i & (w_count != '0);

    always_comb begin
        for (int m = 0; m < NMASTERS; m++) begin
            master_resp_o[m]        = '0;
            master_resp_o[m].gnt    = w_hs & (w_win == idx_t'(m));
            master_resp_o[m].rvalid = w_pop & (w_head == idx_t'(m));
            if (w_pop && (w_head == idx_t'(m))) begin
                master_resp_o[m].rdata = bank_resp_i.rdata;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr   <= '0;
            r_lock_idx <= '0;
            r_lock_vld <= 1'b0;
        end else if (w_hs) begin
            r_rr_ptr   <= wrap_add(w_win, 1);
            r_lock_vld <= 1'b0;
        end else if (w_issue) begin
            r_lock_vld <= 1'b1;
            r_lock_idx <= w_win;
        end else if (r_lock_vld && !w_req_vec[r_lock_idx]) begin
            r_lock_vld <= 1'b0;
        end
    end

    obi_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .DW    (IW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_hs),
        .pop_i   (w_pop),
        .data_i  (w_win),
        .data_o  (w_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_count)
    );

    a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
        !(bank_resp_i.rvalid && w_fifo_empty))
        else $warning("bank rvalid with no outstanding access, dropped");

endmodule

// File: tb/tb_obi_bank_arbiter.sv
// Self-checking bench for obi_bank_arbiter: cycle table plus response-routing scoreboard.
module tb_obi_bank_arbiter;
    import obi_pkg::*;

    localparam int NM = 3;

    logic      clk = 1'b0;
    logic      rst;
    obi_req_t  mreq  [NM];
    obi_resp_t mresp [NM];
    obi_req_t  breq;
    obi_resp_t bresp;
    logic      busy;

    always #5 clk = ~clk;

    obi_bank_arbiter #(
        .NMASTERS        (NM),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .master_req_i  (mreq),
        .master_resp_o (mresp),
        .bank_req_o    (breq),
        .bank_resp_i   (bresp),
        .busy_o        (busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0] exp_q[$];

    typedef struct {
        logic [2:0] req;
        logic       gnt;
        logic       rv;
        int         win;
        logic [2:0] rv_mask;
        logic       busy;
    } vec_t;
    vec_t vecs[$];

    function automatic obi_req_t master_txn(int m, logic on);
        obi_req_t r;
        r.req   = on;
        r.we    = m[0];
        r.be    = 4'hF;
        r.addr  = 32'(m) << 6;
        r.wdata = 32'hCAFE_0000 | 32'(m);
        return r;
    endfunction

    function automatic logic [2:0] gnt_mask();
        logic [2:0] g;
        for (int m = 0; m < NM; m++) g[m] = mresp[m].gnt;
        return g;
    endfunction

    function automatic logic [2:0] rv_mask();
        logic [2:0] v;
        for (int m = 0; m < NM; m++) v[m] = mresp[m].rvalid;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] req, input logic g, input logic rv, input logic [31:0] rd);
        for (int m = 0; m < NM; m++) mreq[m] = master_txn(m, req[m]);
        bresp.gnt    = g;
        bresp.rvalid = rv;
        bresp.rdata  = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [2:0] req, input logic g, input logic rv, input int win,
                           input logic [2:0] rvm, input logic bsy);
        vecs.push_back('{req, g, rv, win, rvm, bsy});
    endtask

    initial begin
        logic [31:0] rd;
        obi_req_t    exp_breq;
        logic [2:0]  exp_g;
        logic [1:0]  w;

`ifdef MOCHILA_ARB_FIXED_PRIO_EN
        add_vec(3'b111, 1, 0,  0, 3'b000, 0);
        add_vec(3'b111, 1, 1,  0, 3'b001, 1);
        add_vec(3'b111, 1, 1,  0, 3'b001, 1);
        add_vec(3'b110, 1, 1,  1, 3'b001, 1);
        add_vec(3'b110, 1, 1,  2, 3'b010, 1);
        add_vec(3'b110, 1, 1,  1, 3'b100, 1);
        add_vec(3'b000, 1, 1, -1, 3'b010, 1);
        add_vec(3'b000, 0, 0, -1, 3'b000, 0);
`else
        // continuous requests, bank always grants: 0,1,2,0,1,2
        add_vec(3'b111, 1, 0,  0, 3'b000, 0);
        add_vec(3'b111, 1, 1,  1, 3'b001, 1);
        add_vec(3'b111, 1, 1,  2, 3'b010, 1);
        add_vec(3'b111, 1, 1,  0, 3'b100, 1);
        add_vec(3'b111, 1, 1,  1, 3'b001, 1);
        add_vec(3'b111, 1, 1,  2, 3'b010, 1);
        add_vec(3'b000, 1, 1, -1, 3'b100, 1);
        add_vec(3'b000, 0, 0, -1, 3'b000, 0);
        // rvalid withheld: two grants, blocked while full, push+pop when full
        add_vec(3'b111, 1, 0,  0, 3'b000, 0);
        add_vec(3'b111, 1, 0,  1, 3'b000, 1);
        add_vec(3'b111, 1, 0, -1, 3'b000, 1);
        add_vec(3'b111, 1, 1,  2, 3'b001, 1);
        add_vec(3'b111, 1, 0, -1, 3'b000, 1);
        add_vec(3'b000, 0, 1, -1, 3'b010, 1);
        add_vec(3'b000, 0, 1, -1, 3'b100, 1);
        add_vec(3'b000, 0, 0, -1, 3'b000, 0);
        // grant lock: master 1 holds the bank while gnt is low and master 2 joins
        add_vec(3'b010, 1, 0,  1, 3'b000, 0);
        add_vec(3'b010, 0, 1,  1, 3'b010, 1);
        add_vec(3'b110, 0, 0,  1, 3'b000, 0);
        add_vec(3'b110, 0, 0,  1, 3'b000, 0);
        add_vec(3'b110, 0, 0,  1, 3'b000, 0);
        add_vec(3'b110, 1, 0,  1, 3'b000, 0);
        add_vec(3'b100, 1, 1,  2, 3'b010, 1);
        add_vec(3'b000, 0, 1, -1, 3'b100, 1);
        add_vec(3'b000, 0, 0, -1, 3'b000, 0);
`endif

        rst = 1'b1;
        drive(3'b111, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        check("reset_gnt", gnt_mask(), 3'b000);
        check("reset_rvalid", rv_mask(), 3'b000);
        check("reset_busy", busy, 1'b0);
        check("reset_bank_req", breq, '0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            rd = 32'hDA7A_0000 + 32'(i);
            drive(vecs[i].req, vecs[i].gnt, vecs[i].rv, rd);
            #1;
            exp_breq = (vecs[i].win >= 0) ? master_txn(vecs[i].win, 1'b1) : '0;
            exp_g    = (vecs[i].win >= 0 && vecs[i].gnt) ? 3'(1 << vecs[i].win) : 3'b000;
            check($sformatf("row%0d_bank_req", i), breq, exp_breq);
            check($sformatf("row%0d_gnt", i), gnt_mask(), exp_g);
            check($sformatf("row%0d_rvalid", i), rv_mask(), vecs[i].rv_mask);
            check($sformatf("row%0d_busy", i), busy, vecs[i].busy);
            if (vecs[i].rv) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL row%0d_sb_underflow: got rvalid expected none outstanding", i);
                end else begin
                    w = exp_q.pop_front();
                    check($sformatf("row%0d_sb_rvalid", i), mresp[w].rvalid, 1'b1);
                    check($sformatf("row%0d_sb_rdata", i), mresp[w].rdata, rd);
                end
            end
            if (exp_g != 3'b000) exp_q.push_back(2'(vecs[i].win));
            tick();
        end
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        // reset with two accesses outstanding, then a late bank rvalid
        drive(3'b001, 1'b1, 1'b0, 32'h0);
        #1;
        check("fill0_gnt", gnt_mask(), 3'b001);
        tick();
        drive(3'b001, 1'b1, 1'b0, 32'h0);
        #1;
        check("fill1_gnt", gnt_mask(), 3'b001);
        check("fill1_busy", busy, 1'b1);
        tick();
        rst = 1'b1;
        drive(3'b001, 1'b1, 1'b0, 32'h0);
        #1;
        check("midrst_gnt", gnt_mask(), 3'b000);
        check("midrst_busy", busy, 1'b0);
        check("midrst_bank_req", breq, '0);
        tick();
        rst = 1'b0;
        drive(3'b000, 1'b0, 1'b1, 32'hBAD0_0000);
        #1;
        check("late_rvalid", rv_mask(), 3'b000);
        check("late_busy", busy, 1'b0);
        tick();
        drive(3'b000, 1'b0, 1'b0, 32'h0);
        #1;
        check("post_busy", busy, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
